multicycle_controller: RTL and testbench

- FSM sequencer that drives the shared datapath as a multicycle machine: one ALU, one unified instruction/data memory, register file.
- Consumes opcode/funct from the instruction register, the datapath `zero` flag and a memory-ready handshake.
- Emits per-state control strobes, replacing the single-cycle combinational decoder's control role.
- Also counts retired instructions and traps on illegal opcodes.

---
 rtl/multicycle_controller_pkg.sv | 88 ++++++++
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/multicycle_controller_output_decode.sv | 89 ++++++++
 rtl/multicycle_controller.sv | 94 +++++++++
 tb/tb_multicycle_controller.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: state codes, instruction
// fields, ALU operations and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_TRAP      = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_XOR = 4'd2,
    ALU_SLT = 4'd3
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU_OUT = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  localparam logic [1:0] ALUB_REGB   = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU     = 2'd0;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd2;
  localparam logic [1:0] PC_SRC_REGA    = 2'd3;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_cntrl;
    logic [1:0] pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Only the R-type functions that reach EXEC_R need an ALU mapping.
  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle. The datapath side is the master
// (drives instruction fields and flags), the controller side is the slave.
interface multicycle_controller_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_wr;
  logic               pc_wr_cond;
  logic               ir_wr;
  logic               iord;
  logic               mem_rd;
  logic               mem_wr;
  logic               reg_wr;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [3:0]         alu_cntrl;
  logic [1:0]         pc_src;
  logic [3:0]         state;
  logic               illegal;
  logic [COUNT_W-1:0] retired;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  pc_wr, pc_wr_cond, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_cntrl, pc_src, state,
           illegal, retired
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output pc_wr, pc_wr_cond, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_cntrl, pc_src, state,
           illegal, retired
  );
endinterface

// File: rtl/multicycle_controller_output_decode.sv
// Moore-style control decode: maps the current state (plus funct in EXEC_R
// and mem_ready in FETCH) to the full datapath strobe vector.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      // PC+4 is computed every fetch cycle but only committed once memory delivers the word.
      S_FETCH: begin
        ctrl_o.mem_rd    = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.pc_src    = PC_SRC_ALU;
        ctrl_o.ir_wr     = mem_ready_i;
        ctrl_o.pc_wr     = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = ALUB_IMM_SH;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
      end
      S_MEM_READ: begin
        ctrl_o.mem_rd = 1'b1;
        ctrl_o.iord   = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_wr = 1'b1;
        ctrl_o.iord   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.reg_dst    = REG_DST_RT;
        ctrl_o.mem_to_reg = WB_MDR;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REGB;
        ctrl_o.alu_cntrl = funct_to_alu(funct_i);
      end
      S_R_WB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.reg_dst    = REG_DST_RD;
        ctrl_o.mem_to_reg = WB_ALU_OUT;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_cntrl = ALU_XOR;
      end
      S_I_WB: begin
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.reg_dst    = REG_DST_RT;
        ctrl_o.mem_to_reg = WB_ALU_OUT;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = ALUB_REGB;
        ctrl_o.alu_cntrl  = ALU_SUB;
        ctrl_o.pc_wr_cond = 1'b1;
        ctrl_o.pc_src     = PC_SRC_ALU_OUT;
      end
      S_JUMP: begin
        ctrl_o.pc_wr  = 1'b1;
        ctrl_o.pc_src = PC_SRC_JUMP;
      end
      S_JAL: begin
        ctrl_o.pc_wr      = 1'b1;
        ctrl_o.pc_src     = PC_SRC_JUMP;
        ctrl_o.reg_wr     = 1'b1;
        ctrl_o.reg_dst    = REG_DST_R31;
        ctrl_o.mem_to_reg = WB_PC;
      end
      S_JR: begin
        ctrl_o.pc_wr  = 1'b1;
        ctrl_o.pc_src = PC_SRC_REGA;
      end
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute, counts
// retired instructions and traps permanently on illegal encodings.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input logic             clk,
  input logic             reset,
  multicycle_controller_if.slave bus
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] retired_q;
  logic               illegal_q;
  logic               retire;
  ctrl_t              ctrl, ctrl_gated;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            case (bus.funct)
              FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
              FN_JR:                  state_d = S_JR;
              default:                state_d = S_TRAP;
            endcase
          end
          OP_XORI: state_d = S_EXEC_I;
          OP_BNE:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // Every path back to FETCH comes from a completing instruction; TRAP never leaves.
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .funct_i     (bus.funct),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  // Reset masks the strobes so FETCH's read request cannot leak out while reset is held.
  assign ctrl_gated = reset ? CTRL_IDLE : ctrl;

  assign bus.pc_wr      = ctrl_gated.pc_wr;
  assign bus.pc_wr_cond = ctrl_gated.pc_wr_cond;
  assign bus.ir_wr      = ctrl_gated.ir_wr;
  assign bus.iord       = ctrl_gated.iord;
  assign bus.mem_rd     = ctrl_gated.mem_rd;
  assign bus.mem_wr     = ctrl_gated.mem_wr;
  assign bus.reg_wr     = ctrl_gated.reg_wr;
  assign bus.reg_dst    = ctrl_gated.reg_dst;
  assign bus.mem_to_reg = ctrl_gated.mem_to_reg;
  assign bus.alu_src_a  = ctrl_gated.alu_src_a;
  assign bus.alu_src_b  = ctrl_gated.alu_src_b;
  assign bus.alu_cntrl  = ctrl_gated.alu_cntrl;
  assign bus.pc_src     = ctrl_gated.pc_src;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks strobes, retire count and trapping.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [19:0] strobes;

  multicycle_controller_if #(.COUNT_W(32)) bus ();

  multicycle_controller #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign strobes = {bus.pc_wr, bus.pc_wr_cond, bus.ir_wr, bus.iord, bus.mem_rd,
                    bus.mem_wr, bus.reg_wr, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_cntrl, bus.pc_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values state=%0d retired=%0d illegal=%b, wanted 0/0/0", bus.state, bus.retired, bus.illegal);
    end
    checks++;
    if (bus.mem_rd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mem_rd got %b wanted 0", bus.mem_rd);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd, bus.ir_wr, bus.pc_wr} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL fetch_wait got %b wanted 100", {bus.mem_rd, bus.ir_wr, bus.pc_wr});
    end
    nextCycle();
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("[TB] FAIL fetch_hold state got %0d wanted 0", bus.state);
    end
  endtask

  task automatic test_add();
    logic [3:0] expState [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [2:0] expWr    [5] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b000};
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.ir_wr, bus.pc_wr, bus.alu_src_b} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL add_fetch got %b wanted 1101", {bus.ir_wr, bus.pc_wr, bus.alu_src_b});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state !== expState[i]) begin
        errors++;
        $display("[TB] FAIL add_state[%0d] got %0d wanted %0d", i, bus.state, expState[i]);
      end
      checks++;
      if ({bus.reg_wr, bus.reg_dst} !== expWr[i]) begin
        errors++;
        $display("[TB] FAIL add_regwr[%0d] got %b wanted %b", i, {bus.reg_wr, bus.reg_dst}, expWr[i]);
      end
      if (i < 4) nextCycle();
    end
    checks++;
    if (bus.retired !== 32'd1) begin
      errors++;
      $display("[TB] FAIL add_retired got %0d wanted 1", bus.retired);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] expState [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rdy      [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] expMem   [8] = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10};
    logic [2:0] expWb    [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000};
    bus.opcode = 6'h23; bus.funct = 6'h00;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (bus.state !== expState[i]) begin
        errors++;
        $display("[TB] FAIL lw_state[%0d] got %0d wanted %0d", i, bus.state, expState[i]);
      end
      checks++;
      if ({bus.mem_rd, bus.iord} !== expMem[i]) begin
        errors++;
        $display("[TB] FAIL lw_memrd_iord[%0d] got %b wanted %b", i, {bus.mem_rd, bus.iord}, expMem[i]);
      end
      checks++;
      if ({bus.reg_wr, bus.mem_to_reg} !== expWb[i]) begin
        errors++;
        $display("[TB] FAIL lw_writeback[%0d] got %b wanted %b", i, {bus.reg_wr, bus.mem_to_reg}, expWb[i]);
      end
      if (i < 7) nextCycle();
    end
    checks++;
    if (bus.retired !== 32'd2) begin
      errors++;
      $display("[TB] FAIL lw_retired got %0d wanted 2", bus.retired);
    end
  endtask

  task automatic test_bne();
    logic [3:0] expState [3] = '{4'd0, 4'd1, 4'd10};
    bus.opcode = 6'h05; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    for (int z = 0; z < 2; z++) begin
      bus.zero = z[0];
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bus.state !== expState[i]) begin
          errors++;
          $display("[TB] FAIL bne%0d_state[%0d] got %0d wanted %0d", z, i, bus.state, expState[i]);
        end
        if (i == 2) begin
          checks++;
          if ({bus.pc_wr_cond, bus.pc_src, bus.alu_cntrl, bus.pc_wr, bus.reg_wr} !== 9'b1_01_0001_0_0) begin
            errors++;
            $display("[TB] FAIL bne%0d_strobes got %b wanted 101000100", z,
                     {bus.pc_wr_cond, bus.pc_src, bus.alu_cntrl, bus.pc_wr, bus.reg_wr});
          end
        end
        nextCycle();
      end
    end
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd4) begin
      errors++;
      $display("[TB] FAIL bne_retired state=%0d retired=%0d wanted 0/4", bus.state, bus.retired);
    end
  endtask

  task automatic test_jal();
    bus.opcode = 6'h03; bus.funct = 6'h00; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    #1;
    nextCycle();
    nextCycle();
    checks++;
    if (bus.state !== 4'd12) begin
      errors++;
      $display("[TB] FAIL jal_state got %0d wanted 12", bus.state);
    end
    checks++;
    if ({bus.pc_wr, bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.pc_src} !== 8'b1_1_10_10_10) begin
      errors++;
      $display("[TB] FAIL jal_strobes got %b wanted 11101010",
               {bus.pc_wr, bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.pc_src});
    end
    nextCycle();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd5) begin
      errors++;
      $display("[TB] FAIL jal_retire state=%0d retired=%0d wanted 0/5", bus.state, bus.retired);
    end
  endtask

  task automatic test_other_ops();
    // SLT: FETCH, DECODE, EXEC_R, R_WB
    bus.opcode = 6'h00; bus.funct = 6'h2A; bus.mem_ready = 1'b1;
    #1;
    nextCycle(); nextCycle();
    checks++;
    if ({bus.state, bus.alu_cntrl, bus.alu_src_a, bus.alu_src_b} !== 11'b0110_0011_1_00) begin
      errors++;
      $display("[TB] FAIL slt_exec got %b wanted 01100011100", {bus.state, bus.alu_cntrl, bus.alu_src_a, bus.alu_src_b});
    end
    nextCycle(); nextCycle();
    // XORI: FETCH, DECODE, EXEC_I, I_WB
    bus.opcode = 6'h0E; bus.funct = 6'h15;
    #1;
    nextCycle(); nextCycle();
    checks++;
    if ({bus.state, bus.alu_cntrl, bus.alu_src_a, bus.alu_src_b} !== 11'b1000_0010_1_10) begin
      errors++;
      $display("[TB] FAIL xori_exec got %b wanted 10000010110", {bus.state, bus.alu_cntrl, bus.alu_src_a, bus.alu_src_b});
    end
    nextCycle();
    checks++;
    if ({bus.state, bus.reg_wr, bus.reg_dst, bus.mem_to_reg} !== 9'b1001_1_00_00) begin
      errors++;
      $display("[TB] FAIL xori_wb got %b wanted 100110000", {bus.state, bus.reg_wr, bus.reg_dst, bus.mem_to_reg});
    end
    nextCycle();
    // JR: FETCH, DECODE, JR
    bus.opcode = 6'h00; bus.funct = 6'h08;
    #1;
    nextCycle(); nextCycle();
    checks++;
    if ({bus.state, bus.pc_wr, bus.pc_src, bus.reg_wr} !== 8'b1101_1_11_0) begin
      errors++;
      $display("[TB] FAIL jr_exec got %b wanted 11011110", {bus.state, bus.pc_wr, bus.pc_src, bus.reg_wr});
    end
    nextCycle();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd8) begin
      errors++;
      $display("[TB] FAIL other_retired state=%0d retired=%0d wanted 0/8", bus.state, bus.retired);
    end
  endtask

  task automatic test_sw_reset_stall();
    bus.opcode = 6'h2B; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    #1;
    nextCycle(); nextCycle(); nextCycle();
    checks++;
    if ({bus.state, bus.mem_wr, bus.iord, bus.mem_rd} !== 7'b0101_110) begin
      errors++;
      $display("[TB] FAIL sw_write got %b wanted 0101110", {bus.state, bus.mem_wr, bus.iord, bus.mem_rd});
    end
    nextCycle();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd9) begin
      errors++;
      $display("[TB] FAIL sw_retire state=%0d retired=%0d wanted 0/9", bus.state, bus.retired);
    end
    nextCycle(); nextCycle();
    bus.mem_ready = 1'b0;
    #1;
    nextCycle(); nextCycle();
    checks++;
    if ({bus.state, bus.mem_wr, bus.iord} !== 6'b0101_11) begin
      errors++;
      $display("[TB] FAIL sw_stall got %b wanted 010111", {bus.state, bus.mem_wr, bus.iord});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.state !== 4'd0 || bus.retired !== 32'd0 || strobes !== 20'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_stall mem_wr=%b state=%0d retired=%0d strobes=%h wanted 0/0/0/0",
               bus.mem_wr, bus.state, bus.retired, strobes);
    end
    reset = 1'b0;
    nextCycle();
    checks++;
    if (bus.state !== 4'd0 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset state=%0d mem_wr=%b wanted 0/0", bus.state, bus.mem_wr);
    end
  endtask

  task automatic test_trap();
    bus.opcode = 6'h3F; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    #1;
    nextCycle();
    checks++;
    if (bus.state !== 4'd1 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trap_decode state=%0d illegal=%b wanted 1/0", bus.state, bus.illegal);
    end
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      #1;
      checks++;
      if (bus.state !== 4'd15 || bus.illegal !== 1'b1 || strobes !== 20'd0 || bus.retired !== 32'd0) begin
        errors++;
        $display("[TB] FAIL trap_hold[%0d] state=%0d illegal=%b strobes=%h retired=%0d wanted 15/1/0/0",
                 i, bus.state, bus.illegal, strobes, bus.retired);
      end
      nextCycle();
    end
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trap_reset state=%0d illegal=%b wanted 0/0", bus.state, bus.illegal);
    end
    reset = 1'b0;
    nextCycle();
    checks++;
    if (bus.state !== 4'd0 || bus.illegal !== 1'b0 || bus.mem_rd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trap_recover state=%0d illegal=%b mem_rd=%b wanted 0/0/1", bus.state, bus.illegal, bus.mem_rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    $display("[TB] starting multicycle_controller bench");
    test_reset();
    test_add();
    test_lw_stall();
    test_bne();
    test_jal();
    test_other_ops();
    test_sw_reset_stall();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
